// File: rtl/uart_pkg.sv
// Shared UART definitions: shifter state encoding and bit-period computation,
// common to the transmitter and receiver.
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Integer truncation is intentional: the bit period is a whole number of clocks.
  function automatic int clks_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1 and wraps, pulsing bit_done
// on the last cycle of each bit period. restart holds it at zero.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic restart,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Gated by restart so a one-cycle bit period cannot fire while idle.
  assign bit_done = (cnt == LAST) && !restart;

  always_ff @(posedge CLK) begin
    if (!RST_N || restart || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cnt.sv
// UART transmitter (8N1/8N2) with a one-byte holding register and a
// VALID/READY byte interface; TX comes straight from a flop.
module uart_tx_cnt
  import uart_pkg::*;
#(
  parameter int BIT_RATE  = 9600,
  parameter int CLK_HZ    = 12_000_000,
  parameter int STOP_BITS = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] DATA,
  input  logic       VALID,
  output logic       READY,
  output logic       TX,
  output logic       BUSY
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BIT_RATE);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] hold_data;
  logic [7:0] shift;
  logic       hold_full;
  logic       tx_q;
  logic       bit_done;
  logic       accept;
  logic       frame_end;
  logic       load;
  logic       shift_en;

  // READY is masked while reset is asserted, never by VALID.
  assign READY     = RST_N & ~hold_full;
  assign accept    = VALID & READY;
  assign BUSY      = (state != ST_IDLE) | hold_full;
  assign TX        = tx_q;
  assign frame_end = (state == ST_STOP) && bit_done && (bit_cnt == LAST_STOP);
  assign load      = hold_full && ((state == ST_IDLE) || frame_end);
  assign shift_en  = bit_done && ((state == ST_START) || (state == ST_DATA));

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .restart (state == ST_IDLE),
    .bit_done(bit_done)
  );

  always_ff @(posedge CLK) begin
    if (accept) hold_data <= DATA;
  end

  // shift[0] always holds the next data bit to put on the line.
  always_ff @(posedge CLK) begin
    if (load) begin
      shift <= hold_data;
    end else if (shift_en) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      hold_full <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      if (accept) hold_full <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (hold_full) begin
            state     <= ST_START;
            hold_full <= 1'b0;
            tx_q      <= 1'b0;
            bit_cnt   <= 3'd0;
          end
        end
        ST_START: begin
          if (bit_done) begin
            state   <= ST_DATA;
            tx_q    <= shift[0];
            bit_cnt <= 3'd0;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            if (bit_cnt == 3'd7) begin
              state   <= ST_STOP;
              tx_q    <= 1'b1;
              bit_cnt <= 3'd0;
            end else begin
              tx_q    <= shift[0];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        default: begin
          // A waiting byte chains straight into the next start bit.
          if (frame_end) begin
            if (hold_full) begin
              state     <= ST_START;
              hold_full <= 1'b0;
              tx_q      <= 1'b0;
              bit_cnt   <= 3'd0;
            end else begin
              state <= ST_IDLE;
              tx_q  <= 1'b1;
            end
          end else if (bit_done) begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_cnt.md
UART_TX_CNT -- requirements
Module: uart_tx_cnt

Interface
REQ-001 Parameter: BIT_RATE, default 9600, serial bit rate in bit/s.
REQ-002 Parameter: CLK_HZ, default 12_000_000, CLK frequency in Hz.
REQ-003 Parameter: STOP_BITS, default 1, number of stop bits per frame; only 1 or 2 are legal.
REQ-004 Port: CLK  input  1  single system clock; all logic on its rising edge.
REQ-005 Port: RST_N  input  1  reset, synchronous, active-low.
REQ-006 Port: DATA  input  8  byte to send; captured on an accepting edge.
REQ-007 Port: VALID  input  1  DATA is valid and is offered for transmission.
REQ-008 Port: READY  output  1  the holding register is empty and can take a byte.
REQ-009 Port: TX  output  1  UART serial line; idle level is 1.
REQ-010 Port: BUSY  output  1  a frame is being shifted or a byte is held.

Function
REQ-011 CLKS_PER_BIT SHALL be CLK_HZ/BIT_RATE with integer truncation (1250 at the defaults); every bit period SHALL last exactly CLKS_PER_BIT cycles.
REQ-012 Frame format SHALL be 8N1 (or 8N2): start bit 0, DATA[0]..DATA[7] LSB first, then STOP_BITS stop bits of 1.
REQ-013 A transfer SHALL occur on any rising edge where VALID=1 and READY=1; DATA is copied into the holding register. DATA or VALID changes after that edge SHALL have no effect on that byte.
REQ-014 READY SHALL equal NOT hold_full; VALID SHALL never combinationally affect READY.
REQ-015 Shifter FSM states SHALL be IDLE, START, DATA, STOP; a bit counter counts 0..7 in DATA and 0..STOP_BITS-1 in STOP.
REQ-016 IDLE -> START on the edge where hold_full=1: shifter loads from hold, hold_full clears, TX=0 from that edge on.
REQ-017 Latency: accept edge E0, load edge E1 = E0+1 cycle; TX SHALL be 0 from E1 for CLKS_PER_BIT cycles.
REQ-018 START -> DATA -> STOP SHALL advance only when the cycle counter reaches CLKS_PER_BIT-1; the counter then wraps to 0.
REQ-019 At the end of the last stop bit, if hold_full=1 the FSM SHALL go directly to START and reload (no idle gap); otherwise it goes to IDLE with TX=1.
REQ-020 A byte accepted while a frame is shifting SHALL wait in hold; a frame in progress SHALL never be altered or truncated.
REQ-021 BUSY SHALL be 1 when the state is not IDLE or hold_full=1, and 0 otherwise.
REQ-022 TX SHALL be driven from a register (glitch-free).

Reset
REQ-023 While RST_N=0 at an edge: the state becomes IDLE, counters go to 0, hold_full=0, TX=1, BUSY=0, and READY is forced to 0.
REQ-024 READY SHALL be 1 from the first cycle after RST_N returns to 1.
REQ-025 Reset mid-frame SHALL abort the frame: TX=1 after that edge, and any held byte is discarded and never sent.

Structure
REQ-026 A shared package uart_pkg SHALL hold the FSM state encoding and the CLKS_PER_BIT computation, also used by uart_rx.
REQ-027 One sub-module, uart_baud_cnt, SHALL provide the per-bit cycle counter with a restart input and a bit_done pulse output.
REQ-028 The rest SHALL sit in uart_tx_cnt: holding register, shifter, FSM and handshake.

Verification
REQ-029 Defaults; send 0x55 from idle -> TX reads 0,1,0,1,0,1,0,1,0,1, each bit exactly 1250 cycles; TX falls 1 cycle after the accept edge; BUSY falls 12500 cycles after TX falls.
REQ-030 VALID held high with 0x41 then 0x42 back-to-back -> the second accept occurs while the first frame is shifting; the second start bit begins exactly 12500 cycles after the first; no idle gap.
REQ-031 VALID held 1 with a constant byte 0xA3 for 3 frames, READY checked -> exactly one accept per READY=1 edge; no byte lost or duplicated.
REQ-032 RST_N=0 for 1 cycle in the middle of DATA bit 3 of 0xFF with 0x00 held -> TX=1 on the next cycle, BUSY=0, 0x00 never sent, READY=1 after reset release.
REQ-033 CLK_HZ=1_000_000, BIT_RATE=100_000, STOP_BITS=2, send 0x00 -> 9 low bits of 10 cycles each, then 20 cycles high; frame is 110 cycles.
REQ-034 A reference-model receiver SHALL check every transmitted byte in all scenarios.
